// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, fetch-state encoding and default widths.
package cpu_pkg;

    localparam int PC_W_DEF    = 10;
    localparam int INSTR_W_DEF = 16;
    localparam int OPC_W       = 6;

    localparam logic [OPC_W-1:0] OP_FIN = 6'b111111;
    localparam logic [OPC_W-1:0] OP_NOP = 6'b111110;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    function automatic logic is_fin(input logic [OPC_W-1:0] op);
        return op == OP_FIN;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Program-memory read port between the fetch unit (master) and instruction memory (slave).
interface fetch_unit_if import cpu_pkg::*; #(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, instruction register and FETCH/EXEC/HALT sequencing.
//   state    | meaning
//   ST_FETCH | request imem[pc], wait for ack, latch instruction into IR
//   ST_EXEC  | IR presented for one cycle, pc advances (pc+1 or jump target)
//   ST_HALT  | FIN executed; everything frozen until reset
module fetch_unit import cpu_pkg::*; #(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    fetch_unit_if.master        imem,
    output logic [INSTR_W-1:0]  instr,
    output logic [OPC_W-1:0]    opcode,
    output logic                instr_valid,
    input  logic                s_inc,
    output logic [PC_W-1:0]     pc,
    output logic                halted
);

    fetch_state_t       state, state_nxt;
    logic [PC_W-1:0]    pc_nxt;
    logic [INSTR_W-1:0] ir, ir_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    assign instr  = ir;
    assign opcode = ir[INSTR_W-1 -: OPC_W];

    // Request and valid are masked by reset so nothing leaks while it is held.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        ir_nxt         = ir;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc;
        instr_valid    = 1'b0;
        halted         = 1'b0;
        case (state)
            ST_FETCH: begin
                imem.imem_req = ~reset;
                if (imem.imem_ack) begin
                    ir_nxt    = imem.imem_data;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                instr_valid = ~reset;
                if (is_fin(opcode)) begin
                    state_nxt = ST_HALT;
                end else begin
                    pc_nxt    = s_inc ? pc + PC_W'(1) : ir[PC_W-1:0];
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALT: begin
                halted    = 1'b1;
                state_nxt = ST_HALT;
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory responder drives the bus, a monitor checks fetches and EXEC pulses.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               s_inc = 1'b0;
    logic [INSTR_W-1:0] instr;
    logic [5:0]         opcode;
    logic               instr_valid;
    logic [PC_W-1:0]    pc;
    logic               halted;

    fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .s_inc       (s_inc),
        .pc          (pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    logic [15:0]     mem [0:1023];
    bit              sinc_tab [0:1023];
    logic [PC_W-1:0] wait_addr;
    int              wait_n;
    int              wcnt;
    bit              mem_en = 1'b1;
    bit              ack_force = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_iv = 0;
    int iv_count = 0;

    typedef struct {logic [PC_W-1:0] addr; int gap;} fexp_t;
    typedef struct {logic [PC_W-1:0] e_pc; logic [15:0] e_instr; int gap;} sb_t;
    fexp_t exp_q[$];
    sb_t   sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push_fetch(input logic [PC_W-1:0] a, input int g);
        fexp_t f;
        f.addr = a;
        f.gap  = g;
        exp_q.push_back(f);
    endtask

    // memory responder
    initial begin
        bus.imem_ack  = 1'b0;
        bus.imem_data = '0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            s_inc = sinc_tab[pc];
            if (ack_force) begin
                bus.imem_ack  = 1'b1;
                bus.imem_data = mem[bus.imem_addr];
            end else if (mem_en && bus.imem_req) begin
                if (bus.imem_addr == wait_addr && wcnt < wait_n) begin
                    wcnt++;
                    bus.imem_ack = 1'b0;
                end else begin
                    wcnt = 0;
                    bus.imem_ack  = 1'b1;
                    bus.imem_data = mem[bus.imem_addr];
                end
            end else begin
                bus.imem_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (instr_valid) begin
                iv_count++;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL iv_unexpected: got instr_valid at pc %0h want none", pc);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    chk("exec_instr", 32'(instr), 32'(e.e_instr));
                    chk("exec_pc", 32'(pc), 32'(e.e_pc));
                    chk("exec_opcode", 32'(opcode), 32'(e.e_instr[15:10]));
                    chk("exec_no_req", 32'(bus.imem_req), 32'd0);
                    if (e.gap != 0) chk("exec_gap", 32'(cyc - last_iv), 32'(e.gap));
                end
                last_iv = cyc;
            end
            if (bus.imem_req && bus.imem_ack && !reset) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL fetch_unexpected: got fetch at addr %0h want none", bus.imem_addr);
                end else begin
                    fexp_t f;
                    sb_t   s;
                    f = exp_q.pop_front();
                    chk("fetch_addr", 32'(bus.imem_addr), 32'(f.addr));
                    s.e_pc    = f.addr;
                    s.e_instr = bus.imem_data;
                    s.gap     = f.gap;
                    sb_q.push_back(s);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        for (int i = 0; i < 1024; i++) begin
            mem[i]      = 16'h0000;
            sinc_tab[i] = 1'b1;
        end
        mem[0]     = 16'h0401;
        mem[1]     = 16'h0802;
        mem[2]     = 16'hF803;
        mem[3]     = 16'h0C04;
        mem[4]     = 16'h1005;
        mem[5]     = 16'h1406;
        mem[6]     = 16'h244A;  sinc_tab[6]     = 1'b0;
        mem[10'h04A] = 16'h0BFF; sinc_tab[10'h04A] = 1'b0;
        mem[10'h3FF] = 16'h1C00; sinc_tab[10'h3FF] = 1'b1;
        wait_addr = 10'd5;
        wait_n    = 3;

        push_fetch(10'h000, 0);
        push_fetch(10'h001, 2);
        push_fetch(10'h002, 2);
        push_fetch(10'h003, 2);
        push_fetch(10'h004, 2);
        push_fetch(10'h005, 5);
        push_fetch(10'h006, 2);
        push_fetch(10'h04A, 2);
        push_fetch(10'h3FF, 2);
        push_fetch(10'h000, 2);

        reset = 1'b1;
        tick();
        tick();
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        reset = 1'b0;

        tick();
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", 32'(bus.imem_addr), 32'd0);

        n = 0;
        while (iv_count < 4 && n < 100) begin tick(); n++; end
        chk("reach_4_exec", 32'(n < 100), 32'd1);
        chk("pc_after4", 32'(pc), 32'd4);

        n = 0;
        while (!(bus.imem_req && bus.imem_addr == 10'd5) && n < 100) begin tick(); n++; end
        chk("reach_addr5", 32'(n < 100), 32'd1);
        cnt = 0;
        while (bus.imem_req && cnt < 20) begin cnt++; tick(); end
        chk("wait_req_cycles", 32'(cnt), 32'd4);
        chk("wait_exec_valid", 32'(instr_valid), 32'd1);
        tick();
        chk("pc_after_wait", 32'(pc), 32'd6);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
        chk("reach_wrap", 32'(n < 200), 32'd1);
        chk("wrap_pc", 32'(pc), 32'd0);
        chk("wrap_exec", 32'(instr_valid), 32'd1);
        tick();
        reset = 1'b1;

        // FIN program: 0 jumps to 7, 7 is FIN (s_inc=1 must be ignored)
        mem[0] = 16'h0007; sinc_tab[0] = 1'b0;
        mem[7] = 16'hFC00; sinc_tab[7] = 1'b1;
        push_fetch(10'h000, 0);
        push_fetch(10'h007, 2);
        tick();
        chk("midfetch_rst_pc", 32'(pc), 32'd0);
        chk("midfetch_rst_instr", 32'(instr), 32'd0);
        tick();
        reset = 1'b0;

        n = 0;
        while (!(instr_valid && pc == 10'd7) && n < 100) begin tick(); n++; end
        chk("reach_fin", 32'(n < 100), 32'd1);
        tick();
        chk("fin_halted", 32'(halted), 32'd1);
        chk("fin_pc", 32'(pc), 32'd7);
        chk("fin_opcode", 32'(opcode), 32'h3F);
        chk("fin_valid", 32'(instr_valid), 32'd0);

        ack_force = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.imem_req || instr_valid || pc != 10'd7 || !halted) cnt++;
        end
        chk("halt_quiet", 32'(cnt), 32'd0);
        chk("halt_instr", 32'(instr), 32'hFC00);
        ack_force = 1'b0;

        // jump-to-9 program for reset-with-ack
        reset = 1'b1;
        mem[0] = 16'h0009; sinc_tab[0] = 1'b0;
        mem[9] = 16'h2222;
        push_fetch(10'h000, 0);
        tick();
        chk("fin_rst_halted", 32'(halted), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("restart_req", 32'(bus.imem_req), 32'd1);
        chk("restart_addr", 32'(bus.imem_addr), 32'd0);

        n = 0;
        while (!(bus.imem_req && pc == 10'd9) && n < 100) begin tick(); n++; end
        chk("reach_addr9", 32'(n < 100), 32'd1);
        reset = 1'b1;
        tick();
        chk("ack_rst_pc", 32'(pc), 32'd0);
        chk("ack_rst_instr", 32'(instr), 32'd0);
        chk("ack_rst_valid", 32'(instr_valid), 32'd0);
        chk("ack_rst_req", 32'(bus.imem_req), 32'd0);
        mem_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("refetch_req", 32'(bus.imem_req), 32'd1);
        chk("refetch_addr", 32'(bus.imem_addr), 32'd0);
        repeat (5) tick();

        chk("fetch_q_empty", 32'(exp_q.size()), 32'd0);
        chk("sb_q_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, meaning the program counter and jump-address width.
REQ-002 The block SHALL have parameter INSTR_W, default 16, meaning the instruction width; opcode = instr[INSTR_W-1 -: 6], jump target = instr[PC_W-1:0].
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 imem_req  output  1  program-memory read request, held until acknowledged.
REQ-006 imem_addr  output  PC_W  read address, equal to pc while imem_req=1.
REQ-007 imem_ack  input  1  memory response; imem_data valid in the same cycle.
REQ-008 imem_data  input  INSTR_W  instruction word from program memory.
REQ-009 instr  output  INSTR_W  instruction register (IR) contents, to the datapath.
REQ-010 opcode  output  6  IR opcode field, to the control unit.
REQ-011 instr_valid  output  1  high for exactly one cycle per executed instruction (EXEC state).
REQ-012 s_inc  input  1  from the control unit; 1 = pc+1, 0 = load jump target; sampled only in EXEC.
REQ-013 pc  output  PC_W  current program counter.
REQ-014 halted  output  1  high while in HALT.

Function
REQ-015 The block SHALL implement FSM states FETCH, EXEC, HALT.
REQ-016 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-017 On FETCH with imem_ack=1, IR SHALL load imem_data and the state SHALL go to EXEC; with imem_ack=0, the block SHALL stay in FETCH with pc and IR unchanged (any wait length).
REQ-018 imem_ack SHALL be ignored outside FETCH.
REQ-019 In EXEC, instr_valid SHALL be 1, imem_req SHALL be 0, and opcode/instr SHALL be stable for the whole cycle.
REQ-020 In EXEC with opcode != 6'b111111, pc SHALL become pc+1 modulo 2^PC_W if s_inc=1, else IR[PC_W-1:0], and the state SHALL return to FETCH.
REQ-021 Fetch-to-fetch latency SHALL be (ack wait cycles + 1) + 1 cycles; zero-wait memory gives one instruction per 2 cycles.
REQ-022 pc+1 at 2^PC_W-1 SHALL wrap to 0 without error indication.
REQ-023 In EXEC with opcode 6'b111111 (FIN), pc SHALL hold, the state SHALL go to HALT, and s_inc SHALL be ignored.
REQ-024 NOP (6'b111110) SHALL get no special handling; pc update SHALL follow s_inc as in REQ-020.
REQ-025 In HALT, imem_req=0, instr_valid=0 and halted=1, with pc and IR frozen; only reset SHALL exit.
REQ-026 Conditional jumps SHALL need no fetch-side logic; the s_inc value the control unit derives from z during EXEC is authoritative.

Reset
REQ-027 While reset=1 at a clock edge, the block SHALL set pc=0, IR=0, state=FETCH, instr_valid=0 and halted=0.
REQ-028 imem_req SHALL be 0 while reset is asserted and SHALL be 1 in the first cycle after reset deasserts.
REQ-029 Reset during a pending fetch SHALL abandon it; a same-cycle imem_ack SHALL be discarded.
REQ-030 Reset during EXEC SHALL suppress the pc update.
REQ-031 Reset SHALL take priority over every other event.

Structure
REQ-032 Shared package cpu_pkg SHALL hold OP_FIN=6'b111111, OP_NOP=6'b111110, the fetch-state enum, and the default PC_W/INSTR_W constants; the control unit SHALL use the same opcode constants.
REQ-033 The block SHALL be a single module with no sub-modules; the next-pc mux and incrementer SHALL be inline.

Verification
REQ-034 Zero-wait sequential run: reset, ack in the same cycle as every req, s_inc=1 for 4 instructions -> imem_addr sequence 0,1,2,3, instr_valid pulses 2 cycles apart, pc=4.
REQ-035 Wait states: ack delayed 3 cycles at pc=5 -> imem_req held 4 cycles at addr 5, one instr_valid pulse, pc=6.
REQ-036 Jump: IR=0x244A (opcode 001001, target 0x04A), s_inc=0 -> next imem_addr=0x04A; with pc=0x3FF and s_inc=1 -> next imem_addr=0x000.
REQ-037 FIN: IR opcode 111111 at pc=7 -> halted=1 the cycle after EXEC, pc=7, no further imem_req for 20 cycles; reset -> imem_req=1 at addr 0.
REQ-038 Reset mid-fetch: reset coinciding with imem_ack at pc=9 -> IR=0, pc=0, no instr_valid, fetch restarts at addr 0.
